// File: rtl/seq15_pkg.sv
// Shared definitions for the 15-step run-control sequencer: state constants,
// control FSM encodings and the sequence successor rule.
package seq15_pkg;

    localparam logic [3:0] S0  = 4'd0;
    localparam logic [3:0] S1  = 4'd1;
    localparam logic [3:0] S2  = 4'd2;
    localparam logic [3:0] S3  = 4'd3;
    localparam logic [3:0] S4  = 4'd4;
    localparam logic [3:0] S5  = 4'd5;
    localparam logic [3:0] S6  = 4'd6;
    localparam logic [3:0] S7  = 4'd7;
    localparam logic [3:0] S8  = 4'd8;
    localparam logic [3:0] S9  = 4'd9;
    localparam logic [3:0] S10 = 4'd10;
    localparam logic [3:0] S11 = 4'd11;
    localparam logic [3:0] S12 = 4'd12;
    localparam logic [3:0] S13 = 4'd13;
    localparam logic [3:0] S14 = 4'd14;

    localparam logic [3:0] LAST_STATE = S14;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } ctrlState_t;

    // The final state and any out-of-range value both fall back to S0.
    function automatic logic [3:0] successor(input logic [3:0] cur, input logic [3:0] last);
        return (cur >= last) ? S0 : cur + 4'd1;
    endfunction

endpackage

// File: rtl/seq15_controller_if.sv
// User-control and status bundle between the control source and the sequencer.
interface seq15_controller_if #(parameter int PRESCALE_W = 8);

    logic                  Start_i;
    logic                  Stop_i;
    logic                  Pause_i;
    logic                  Step_i;
    logic                  Load_i;
    logic [3:0]            LoadValue_i;
    logic                  OneShot_i;
    logic [PRESCALE_W-1:0] Div_i;
    logic [3:0]            State_o;
    logic                  Busy_o;
    logic                  Wrap_o;
    logic                  Done_o;
    logic [1:0]            CtrlState_o;

    modport master (
        output Start_i, Stop_i, Pause_i, Step_i, Load_i, LoadValue_i, OneShot_i, Div_i,
        input  State_o, Busy_o, Wrap_o, Done_o, CtrlState_o
    );

    modport slave (
        input  Start_i, Stop_i, Pause_i, Step_i, Load_i, LoadValue_i, OneShot_i, Div_i,
        output State_o, Busy_o, Wrap_o, Done_o, CtrlState_o
    );

endinterface

// File: rtl/seq15_prescaler.sv
// Advance-rate prescaler: ticks once the count reaches Div_i, then restarts.
module seq15_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic                  Clear_i,
    input  logic                  Enable_i,
    input  logic [PRESCALE_W-1:0] Div_i,
    output logic                  Tick_o
);

    logic [PRESCALE_W-1:0] count;

    // Using >= lets a mid-run decrease of Div_i tick immediately.
    assign Tick_o = (count >= Div_i);

    always_ff @(posedge Clk_i) begin
        if (Reset_i || Clear_i) begin
            count <= '0;
        end else if (Enable_i) begin
            if (Tick_o) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq15_controller.sv
// Run-control sequencer top: control FSM, sequence state register and the
// registered wrap/done/busy pulses.
module seq15_controller #(
    parameter int         PRESCALE_W = 8,
    parameter logic [3:0] LAST_STATE = 4'd14
) (
    input logic               Clk_i,
    input logic               Reset_i,
    seq15_controller_if.slave bus
);

    import seq15_pkg::*;

    ctrlState_t ctrlState, ctrlNext;
    logic [3:0] seqState, seqNext, loadSafe;
    logic       busyQ, wrapQ, doneQ;
    logic       wrapNext, doneNext, prescClear, advance, tick;

    seq15_prescaler #(.PRESCALE_W(PRESCALE_W)) prescaler (
        .Clk_i    (Clk_i),
        .Reset_i  (Reset_i),
        .Clear_i  (prescClear),
        .Enable_i (ctrlState == RUN),
        .Div_i    (bus.Div_i),
        .Tick_o   (tick)
    );

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            ctrlState <= IDLE;
            seqState  <= S0;
            busyQ     <= 1'b0;
            wrapQ     <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            ctrlState <= ctrlNext;
            seqState  <= seqNext;
            busyQ     <= (ctrlNext == RUN);
            wrapQ     <= wrapNext;
            doneQ     <= doneNext;
        end
    end

    // Priority is Stop > Load > Start/Pause/Step; advances are resolved last so
    // a one-shot wrap can override a coincident Pause.
    always_comb begin
        ctrlNext   = ctrlState;
        seqNext    = seqState;
        wrapNext   = 1'b0;
        doneNext   = 1'b0;
        prescClear = 1'b0;
        advance    = 1'b0;
        loadSafe   = (bus.LoadValue_i > LAST_STATE) ? S0 : bus.LoadValue_i;

        case (ctrlState)
            IDLE: begin
                if (!bus.Stop_i) begin
                    if (bus.Load_i) begin
                        seqNext = loadSafe;
                    end else if (bus.Start_i) begin
                        ctrlNext   = RUN;
                        prescClear = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.Stop_i) begin
                    ctrlNext = IDLE;
                end else begin
                    advance = tick;
                    if (bus.Pause_i) begin
                        ctrlNext = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (bus.Stop_i) begin
                    ctrlNext = IDLE;
                end else if (bus.Load_i) begin
                    seqNext = loadSafe;
                end else if (bus.Start_i) begin
                    ctrlNext   = RUN;
                    prescClear = 1'b1;
                end else begin
                    advance = bus.Step_i;
                end
            end
            default: ctrlNext = IDLE;
        endcase

        if (advance) begin
            seqNext = successor(seqState, LAST_STATE);
            if (seqState == LAST_STATE) begin
                wrapNext = 1'b1;
                if (bus.OneShot_i) begin
                    doneNext = 1'b1;
                    ctrlNext = IDLE;
                end
            end
        end
    end

    assign bus.State_o     = seqState;
    assign bus.CtrlState_o = ctrlState;
    assign bus.Busy_o      = busyQ;
    assign bus.Wrap_o      = wrapQ;
    assign bus.Done_o      = doneQ;

endmodule

// File: tb/tb_seq15_controller.sv
// Directed self-checking bench for seq15_controller with hand-computed expectations.
module tb_seq15_controller;

    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    seq15_controller_if #(.PRESCALE_W(PW)) bus ();

    seq15_controller #(.PRESCALE_W(PW), .LAST_STATE(4'd14)) dut (
        .Clk_i   (clk),
        .Reset_i (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle's worth of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic r, input logic start, input logic stop,
                                 input logic pause, input logic step, input logic load,
                                 input logic [3:0] lv);
        rst             = r;
        bus.Start_i     = start;
        bus.Stop_i      = stop;
        bus.Pause_i     = pause;
        bus.Step_i      = step;
        bus.Load_i      = load;
        bus.LoadValue_i = lv;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.Start_i = 1'b0;
        bus.Stop_i  = 1'b0;
        bus.Pause_i = 1'b0;
        bus.Step_i  = 1'b0;
        bus.Load_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic checkAll(input string tag, input logic [3:0] st, input logic [1:0] cs,
                            input logic busy, input logic wrap, input logic done);
        checkOutput({tag, ".state"}, bus.State_o, st);
        checkOutput({tag, ".ctrl"}, bus.CtrlState_o, cs);
        checkOutput({tag, ".busy"}, bus.Busy_o, busy);
        checkOutput({tag, ".wrap"}, bus.Wrap_o, wrap);
        checkOutput({tag, ".done"}, bus.Done_o, done);
    endtask

    initial begin
        rst             = 1'b1;
        bus.Start_i     = 1'b0;
        bus.Stop_i      = 1'b0;
        bus.Pause_i     = 1'b0;
        bus.Step_i      = 1'b0;
        bus.Load_i      = 1'b0;
        bus.LoadValue_i = 4'd0;
        bus.OneShot_i   = 1'b0;
        bus.Div_i       = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 4'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 4'd0);
        checkAll("reset", 4'd0, 2'd0, 0, 0, 0);

        // Step and Pause are ignored in IDLE.
        applyStimulus(0, 0, 0, 1, 1, 0, 4'd0);
        checkAll("idleIgnore", 4'd0, 2'd0, 0, 0, 0);

        // Continuous, Div=0: one advance per cycle, wrap every 15.
        bus.Div_i = 8'd0;
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd0);
        checkAll("contStart", 4'd0, 2'd1, 1, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            idle(1);
            checkOutput($sformatf("cont.state%0d", k), bus.State_o, k % 15);
            checkOutput($sformatf("cont.wrap%0d", k), bus.Wrap_o, (k % 15) == 0);
            checkOutput($sformatf("cont.done%0d", k), bus.Done_o, 0);
        end
        // Stop coinciding with a tick: no advance.
        applyStimulus(0, 0, 1, 0, 0, 0, 4'd0);
        checkAll("stopTick", 4'd0, 2'd0, 0, 0, 0);

        // One-shot, Div=3: advance every 4 cycles, done after 15 advances.
        bus.Div_i     = 8'd3;
        bus.OneShot_i = 1'b1;
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd0);
        checkAll("osStart", 4'd0, 2'd1, 1, 0, 0);
        for (int n = 1; n < 60; n++) begin
            idle(1);
            checkOutput($sformatf("os.state%0d", n), bus.State_o, n / 4);
            checkOutput($sformatf("os.wrap%0d", n), bus.Wrap_o, 0);
        end
        idle(1);
        checkAll("osDone", 4'd0, 2'd0, 0, 1, 1);
        idle(1);
        checkAll("osAfter", 4'd0, 2'd0, 0, 0, 0);

        // Div=1 continuous; pause at 5, step, load, step through wrap.
        bus.Div_i     = 8'd1;
        bus.OneShot_i = 1'b0;
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd0);
        idle(10);
        checkAll("runTo5", 4'd5, 2'd1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 4'd0);
        checkAll("pause5", 4'd5, 2'd2, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 4'd0);
        checkOutput("step6", bus.State_o, 6);
        applyStimulus(0, 0, 0, 0, 1, 0, 4'd0);
        checkOutput("step7", bus.State_o, 7);
        idle(3);
        checkAll("pauseHold", 4'd7, 2'd2, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 4'd13);
        checkOutput("load13", bus.State_o, 13);
        applyStimulus(0, 0, 0, 0, 1, 0, 4'd0);
        checkOutput("step14", bus.State_o, 14);
        applyStimulus(0, 0, 0, 0, 1, 0, 4'd0);
        checkAll("stepWrap", 4'd0, 2'd2, 0, 1, 0);
        idle(1);
        checkOutput("stepWrapEnd", bus.Wrap_o, 0);

        // Start with Step in PAUSE: Start wins.
        applyStimulus(0, 1, 0, 0, 1, 0, 4'd0);
        checkAll("startStep", 4'd0, 2'd1, 1, 0, 0);
        // Pause with a coinciding tick: advance and pause.
        idle(1);
        checkOutput("preTick", bus.State_o, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 4'd0);
        checkAll("pauseTick", 4'd1, 2'd2, 0, 0, 0);
        // Load wins over Step in PAUSE.
        applyStimulus(0, 0, 0, 0, 1, 1, 4'd3);
        checkOutput("loadStep", bus.State_o, 3);
        applyStimulus(0, 0, 1, 0, 0, 0, 4'd0);
        checkAll("stopPause", 4'd3, 2'd0, 0, 0, 0);

        // Out-of-range load clamps to 0; load during RUN is ignored.
        applyStimulus(0, 0, 0, 0, 0, 1, 4'd15);
        checkOutput("load15", bus.State_o, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 4'd9);
        checkOutput("load9", bus.State_o, 9);
        bus.Div_i = 8'd0;
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 4'd2);
        checkAll("loadInRun", 4'd10, 2'd1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 4'd0);
        checkOutput("stopAt10", bus.State_o, 10);

        // Reset mid-run at state 9, together with Start.
        applyStimulus(0, 0, 0, 0, 0, 1, 4'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd0);
        idle(9);
        checkAll("runTo9", 4'd9, 2'd1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 4'd0);
        checkAll("resetMid", 4'd0, 2'd0, 0, 0, 0);
        idle(2);
        checkAll("resetHold", 4'd0, 2'd0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq15_controller.md
# seq15_controller

Run-control sequencer for the team's 15-step state sequence (S0..S14, wrapping S14 -> S0). It owns the state register, paces advances with a programmable prescaler, and supports start / stop / pause / single-step / load. In one-shot or continuous mode it reports every wrap and the completion of a one-shot pass. It sits between the user-control inputs (buttons or a host) and the display/decode logic that consumes `State_o`.

## Interface
- `PRESCALE_W`, default 8: width of the prescaler divisor and counter.
- `LAST_STATE`, default 4'd14: final state of the sequence; its successor is S0.
- `Clk_i`  in  1  single clock; all logic is rising-edge.
- `Reset_i`  in  1  synchronous, active-high reset.
- `Start_i`  in  1  level-sampled; enter or resume RUN.
- `Stop_i`  in  1  abort to IDLE; `State_o` is kept.
- `Pause_i`  in  1  RUN -> PAUSE.
- `Step_i`  in  1  advance one state while in PAUSE.
- `Load_i`  in  1  load `LoadValue_i` into the state register (IDLE or PAUSE only).
- `LoadValue_i`  in  4  value to load; values > LAST_STATE load 0.
- `OneShot_i`  in  1  1 = stop after the wrap to S0; 0 = continuous.
- `Div_i`  in  PRESCALE_W  advance period in RUN = `Div_i` + 1 cycles.
- `State_o`  out  4  current sequence state (registered).
- `Busy_o`  out  1  high iff the control FSM is in RUN.
- `Wrap_o`  out  1  one-cycle pulse, registered with the LAST_STATE -> S0 transition.
- `Done_o`  out  1  one-cycle pulse when a one-shot pass completes.
- `CtrlState_o`  out  2  control FSM state: IDLE = 00, RUN = 01, PAUSE = 10.

## Operation
- **Reset values:** `State_o` = 0, `CtrlState_o` = IDLE, `Busy_o` = `Wrap_o` = `Done_o` = 0, prescaler count = 0. Reset overrides everything, including in mid-run.
- **Successor function:** `State_o` == LAST_STATE, or any value > LAST_STATE -> 0; otherwise `State_o` + 1.
- **Input priority each cycle:** `Reset_i` > `Stop_i` > `Load_i` > `Start_i` / `Pause_i` / `Step_i`.
- **IDLE:**
  - `Start_i` -> RUN, prescaler cleared.
  - `Load_i` -> load the state register.
  - `Step_i` and `Pause_i` are ignored.
- **RUN:**
  - The prescaler increments each cycle. A tick occurs when count >= `Div_i`; the count then returns to 0. Using >= makes a mid-run decrease of `Div_i` tick immediately.
  - Each tick advances the state.
  - `Stop_i` -> IDLE with no advance, even if a tick coincides.
  - `Pause_i` -> PAUSE. A coincident tick still advances.
  - `Start_i` and `Load_i` are ignored.
- **PAUSE:**
  - The prescaler is held.
  - `Step_i` advances exactly one state per asserted cycle.
  - `Start_i` -> RUN, prescaler cleared. If `Start_i` and `Step_i` coincide, Start wins and no step occurs.
  - `Load_i` loads the state register; a load wins over a coincident `Step_i`.
  - `Stop_i` -> IDLE.
- **Wrap:** any advance from LAST_STATE (RUN tick or PAUSE step) pulses `Wrap_o`.
  - If `OneShot_i` = 1 at that advance: `Done_o` pulses in the same cycle as `Wrap_o`, and the FSM enters IDLE with `State_o` = 0.
  - Advances from an out-of-range value to 0 pulse neither `Wrap_o` nor `Done_o`.

## Timing
- All outputs are registered; there is no combinational input -> output path.
- `Start_i` at cycle t: `Busy_o` = 1 at t+1. First tick in cycle t+1+`Div_i`; `State_o` changes at t+2+`Div_i`.
- Steady RUN: one advance every `Div_i` + 1 cycles (every cycle when `Div_i` = 0).
- `Step_i`, `Load_i` and `Stop_i` take effect on the next edge, 1-cycle latency.
- `Wrap_o` and `Done_o` are high for exactly one cycle, aligned with `State_o` becoming 0.

## Structure
- **Shared package `seq15_pkg`:**
  - state constants S0..S14 (4-bit);
  - LAST_STATE;
  - control FSM encodings IDLE, RUN, PAUSE (2-bit);
  - a successor function implementing the rule above.
- **Sub-module `seq15_prescaler`:**
  - inputs: `Clk_i`, `Reset_i`, `Clear_i`, `Enable_i`, `Div_i`;
  - output: `Tick_o`, which is combinational on the count register;
  - the count is cleared by `Clear_i` or after a tick, and holds when not enabled.
- **Top level:** control FSM, state register, pulse registers.

## Test plan
- Reset, then `Div_i` = 0, `OneShot_i` = 0, `Start_i` 1 cycle -> `State_o` steps 0..14, 0, 1... one per cycle from t+2; `Wrap_o` pulses once every 15 cycles; `Done_o` stays 0.
- `Div_i` = 3, `OneShot_i` = 1, Start from 0 -> advance every 4 cycles. After 15 advances, `State_o` = 0, `Wrap_o` and `Done_o` both pulse in the same cycle, then `CtrlState_o` = IDLE and `Busy_o` = 0.
- RUN, then `Pause_i` at `State_o` = 5, then `Step_i` for 2 cycles -> `State_o` 6, 7, prescaler frozen. Then `Load_i` with `LoadValue_i` = 13 -> 13. Then `Step_i` twice -> 14, then 0 with a `Wrap_o` pulse.
- `Load_i` with `LoadValue_i` = 15 in IDLE -> `State_o` = 0. `Load_i` in RUN -> ignored.
- Simultaneous inputs:
  - `Stop_i` with a tick in RUN -> no advance, IDLE;
  - `Start_i` with `Step_i` in PAUSE -> RUN, no step;
  - `Pause_i` with a tick -> advance and PAUSE.
- `Reset_i` asserted mid-RUN at `State_o` = 9 -> next cycle all outputs at their reset values. The bench also checks `Reset_i` asserted together with `Start_i`.
